mips_mc_control: RTL
====================

Name: mips_mc_control

Overview:
- Multi-cycle control sequencer for the mipscpu datapath (register file, ALU, data memory).
- Captures an instruction word when newInstr is strobed, decodes it, then walks the datapath through DECODE/EXEC/MEM/WB.
- Drives one-cycle enables to the register file and data memory, and ALU control, so that exactly one instruction completes per strobe.
- Sits between the instruction source (bench/loader) and the datapath; replaces ad-hoc combinational control.

Parameters:
- COUNT_W, 16, width of the retired-instruction counter instrCount.

Ports:
- Clk  in  1  system clock; all state updates on rising edge.
- Reset  in  1  synchronous, active-high reset.
- instrWord  in  32  instruction to execute; sampled only on accept.
- newInstr  in  1  start strobe; a 0→1 transition requests execution.
- ALUZero  in  1  ALU zero flag from datapath, used by beq.
- IR  out  32  latched instruction register.
- busy  out  1  high from accept through DONE inclusive.
- done  out  1  one-cycle pulse in DONE state.
- illegal  out  1  high in DONE cycle when the opcode/funct is unsupported.
- overrun  out  1  one-cycle pulse when a start edge arrives while not IDLE.
- RegWrite  out  1  register file write enable.
- RegDst  out  1  1 = write to rd, 0 = write to rt.
- writeReg  out  5  destination register number (rd or rt per RegDst).
- MemRead  out  1  data memory read enable.
- MemWrite  out  1  data memory write enable.
- MemtoReg  out  1  1 = write-back from memory, 0 = from ALU.
- ALUSrc  out  1  1 = sign-extended immediate, 0 = rt.
- ALUCtl  out  4  ALU operation.
- branchTaken  out  1  high in DONE cycle for a beq whose ALUZero was 1 during EXEC.
- instrCount  out  COUNT_W  count of completed legal instructions; wraps modulo 2^COUNT_W.

Behaviour:
- Reset (synchronous, when Reset=1 at a rising edge):
  - state goes to IDLE; IR, instrCount and all outputs go to 0, except ALUCtl, which goes to 0010.
  - The edge-detect register loads the current newInstr value, so a strobe held high through reset does not start execution.
  - Reset overrides every other event, including mid-instruction: no write enable may assert in the cycle after reset.
- Start detection: start = newInstr & ~newInstr_q, where newInstr_q is newInstr registered every cycle.
  - If start occurs in IDLE: IR <= instrWord, next state is DECODE.
  - If start occurs in any other state: the instruction is ignored and overrun pulses for 1 cycle.
- Supported instructions; any other opcode, or any other funct under opcode 000000, is illegal:
  - opcode 000000 (R-type), funct 100000 add, 100010 sub, 100100 and, 100101 or, 101010 slt.
  - 100011 lw.
  - 101011 sw.
  - 000100 beq.
  - 001000 addi.
- ALUCtl encoding: 0010 add, 0110 sub, 0000 and, 0001 or, 0111 slt.
  - lw, sw and addi use add; beq uses sub.
  - ALUCtl holds the instruction's value from EXEC through WB; it is 0010 in IDLE, DECODE and DONE.
- FSM states: IDLE, DECODE, EXEC, MEM, WB, DONE. Cycle n = the n-th cycle after the accept edge.
  - R-type and addi: DECODE(1), EXEC(2), WB(3), DONE(4).
  - lw: DECODE(1), EXEC(2), MEM(3), WB(4), DONE(5).
  - sw: DECODE(1), EXEC(2), MEM(3), DONE(4).
  - beq: DECODE(1), EXEC(2), DONE(3).
  - illegal: DECODE(1), DONE(2).
  - DONE always returns to IDLE on the next edge, so at least 1 IDLE cycle separates instructions.
- Enables are Moore outputs of the state and IR:
  - ALUSrc = 1 for lw/sw/addi, valid EXEC..WB.
  - MemRead = 1 only in MEM for lw; MemWrite = 1 only in MEM for sw.
  - RegWrite = 1 only in WB, and is forced to 0 when writeReg == 0.
  - RegDst = 1 for R-type; writeReg = IR[15:11] if RegDst else IR[20:16], held EXEC..WB, 0 elsewhere.
  - MemtoReg = 1 for lw, held MEM..WB.
- branchTaken: ALUZero is sampled at the end of EXEC; branchTaken = 1 in DONE only for beq.
- DONE cycle: illegal = 1 for an illegal instruction. For a legal instruction, instrCount increments by 1 at the DONE→IDLE edge; illegal instructions do not count.
- At most one of MemRead, MemWrite, RegWrite is high in any cycle.

Test Plan:
- lw $1,0($0) (0x8C010000), one-cycle newInstr pulse -> cycle 2 ALUSrc=1, ALUCtl=0010; cycle 3 MemRead=1; cycle 4 RegWrite=1, writeReg=1, MemtoReg=1; cycle 5 done=1; instrCount=1.
- add $3,$1,$2 (0x00221820) -> cycle 3 RegWrite=1, RegDst=1, writeReg=3, ALUCtl=0010; MemRead/MemWrite never high; done in cycle 4.
- sw $2,4($0) (0xAC020004), then beq $1,$2 (0x10220004) with ALUZero=1 in EXEC -> sw: MemWrite=1 in cycle 3 only, no RegWrite. beq: ALUCtl=0110 in cycle 2, branchTaken=1 and done=1 in cycle 3. instrCount=2.
- addi $0,$1,5 (0x20200005) -> RegWrite stays 0 in WB; done in cycle 4. Opcode 0xFC000000 -> done=1 and illegal=1 in cycle 2; instrCount unchanged.
- Second newInstr edge in cycle 2 of an lw -> overrun=1 for one cycle; IR unchanged; lw completes in cycle 5. newInstr held high 10 cycles -> exactly one accept.
- Reset=1 during MEM of an lw (newInstr held 1) -> next cycle state IDLE, all enables 0, IR=0, instrCount=0; no RegWrite ever asserted; no restart after Reset drops.

Source files
------------

// File: rtl/mips_mc_control_if.sv
// Instruction-source / datapath-control bundle for the multi-cycle MIPS sequencer.
// master = instruction source side, slave = sequencer side.
interface mips_mc_control_if #(
   parameter int COUNT_W = 16
);
   logic [31:0]        instrWord;
   logic               newInstr;
   logic               ALUZero;
   logic [31:0]        IR;
   logic               busy;
   logic               done;
   logic               illegal;
   logic               overrun;
   logic               RegWrite;
   logic               RegDst;
   logic [4:0]         writeReg;
   logic               MemRead;
   logic               MemWrite;
   logic               MemtoReg;
   logic               ALUSrc;
   logic [3:0]         ALUCtl;
   logic               branchTaken;
   logic [COUNT_W-1:0] instrCount;

   modport master (
      output instrWord, newInstr, ALUZero,
      input  IR, busy, done, illegal, overrun, RegWrite, RegDst, writeReg,
             MemRead, MemWrite, MemtoReg, ALUSrc, ALUCtl, branchTaken, instrCount
   );

   modport slave (
      input  instrWord, newInstr, ALUZero,
      output IR, busy, done, illegal, overrun, RegWrite, RegDst, writeReg,
             MemRead, MemWrite, MemtoReg, ALUSrc, ALUCtl, branchTaken, instrCount
   );
endinterface

// File: rtl/mips_mc_control.sv
// Multi-cycle control sequencer: latches one instruction per newInstr edge and
// walks the datapath through DECODE/EXEC/MEM/WB with Moore-style enables.
module mips_mc_control #(
   parameter int COUNT_W = 16
) (
   input logic              Clk,
   input logic              Reset,
   mips_mc_control_if.slave bus
);
   typedef enum logic [2:0] {IDLE, DECODE, EXEC, MEM, WB, DONE} state_t;

   state_t             state, state_nx;
   logic [31:0]        ir;
   logic               newinstr_q, zero_q, overrun_q;
   logic [COUNT_W-1:0] cnt;
   logic               start;

   logic [5:0] op, fn;
   logic       is_r, is_lw, is_sw, is_beq, is_addi, legal;
   logic [3:0] alu_op;

   assign start = bus.newInstr & ~newinstr_q;
   assign op    = ir[31:26];
   assign fn    = ir[5:0];

   always_comb begin
      is_r    = 1'b0;
      is_lw   = 1'b0;
      is_sw   = 1'b0;
      is_beq  = 1'b0;
      is_addi = 1'b0;
      alu_op  = 4'b0010;
      case (op)
         6'b000000: begin
            is_r = 1'b1;
            case (fn)
               6'b100000: alu_op = 4'b0010;
               6'b100010: alu_op = 4'b0110;
               6'b100100: alu_op = 4'b0000;
               6'b100101: alu_op = 4'b0001;
               6'b101010: alu_op = 4'b0111;
               default:   is_r   = 1'b0;
            endcase
         end
         6'b100011: is_lw   = 1'b1;
         6'b101011: is_sw   = 1'b1;
         6'b000100: begin
            is_beq = 1'b1;
            alu_op = 4'b0110;
         end
         6'b001000: is_addi = 1'b1;
         default: ;
      endcase
      legal = is_r | is_lw | is_sw | is_beq | is_addi;
   end

   always_ff @(posedge Clk) begin
      if (Reset) state <= IDLE;
      else       state <= state_nx;
   end

   // Edge-detect register loads newInstr even in reset so a held strobe cannot restart.
   always_ff @(posedge Clk) begin
      newinstr_q <= bus.newInstr;
      if (Reset) begin
         ir        <= '0;
         cnt       <= '0;
         zero_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         overrun_q <= start & (state != IDLE);
         if (state == IDLE && start) ir <= bus.instrWord;
         if (state == EXEC) zero_q <= bus.ALUZero;
         if (state == DONE && legal) cnt <= cnt + COUNT_W'(1);
      end
   end

   logic       in_ex, regdst, alusrc, memread, memwrite, memtoreg, regwrite;
   logic       done, illegal, branch;
   logic [4:0] wreg;
   logic [3:0] aluctl;

   always_comb begin
      state_nx = state;
      case (state)
         IDLE:    if (start) state_nx = DECODE;
         DECODE:  state_nx = legal ? EXEC : DONE;
         EXEC:    state_nx = (is_lw | is_sw) ? MEM : (is_beq ? DONE : WB);
         MEM:     state_nx = is_lw ? WB : DONE;
         WB:      state_nx = DONE;
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase

      in_ex    = (state == EXEC) | (state == MEM) | (state == WB);
      regdst   = in_ex & is_r;
      alusrc   = in_ex & (is_lw | is_sw | is_addi);
      aluctl   = in_ex ? alu_op : 4'b0010;
      wreg     = in_ex ? (is_r ? ir[15:11] : ir[20:16]) : 5'd0;
      memread  = (state == MEM) & is_lw;
      memwrite = (state == MEM) & is_sw;
      memtoreg = ((state == MEM) | (state == WB)) & is_lw;
      // $0 is hardwired zero, so a write to it is suppressed at the enable.
      regwrite = (state == WB) & (wreg != 5'd0);
      done     = (state == DONE);
      illegal  = done & ~legal;
      branch   = done & is_beq & zero_q;
   end

   assign bus.IR          = ir;
   assign bus.busy        = (state != IDLE);
   assign bus.done        = done;
   assign bus.illegal     = illegal;
   assign bus.overrun     = overrun_q;
   assign bus.RegWrite    = regwrite;
   assign bus.RegDst      = regdst;
   assign bus.writeReg    = wreg;
   assign bus.MemRead     = memread;
   assign bus.MemWrite    = memwrite;
   assign bus.MemtoReg    = memtoreg;
   assign bus.ALUSrc      = alusrc;
   assign bus.ALUCtl      = aluctl;
   assign bus.branchTaken = branch;
   assign bus.instrCount  = cnt;
endmodule
